// File: rtl/trng_arbiter_pkg.sv
// trng_arbiter_pkg: state encoding and width helpers shared by the TRNG arbiter files
package trng_arbiter_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_REARM   = 2'd2;
    localparam logic [1:0] S_DELIVER = 2'd3;

    function automatic int samples_of(int out_w, int trng_w);
        return out_w / trng_w;
    endfunction

    function automatic int ctr_w(int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int idx_w(int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/trng_arbiter_if.sv
// trng_arbiter_if: requester-side request/response bundle of the TRNG arbiter
interface trng_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int OUT_WIDTH = 32
);
    logic [NUM_REQ-1:0]   req_i;
    logic [NUM_REQ-1:0]   rsp_valid_o;
    logic                 rsp_err_o;
    logic [OUT_WIDTH-1:0] rsp_data_o;

    modport master (output req_i, input rsp_valid_o, rsp_err_o, rsp_data_o);
    modport slave  (input req_i, output rsp_valid_o, rsp_err_o, rsp_data_o);
endinterface

// File: rtl/trng_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, searches upward from ptr_i+1 with wrap
module rr_pick
    import trng_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IW     = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);
    logic [IW-1:0] j;

    // scan from lowest priority to highest so the nearest set bit after ptr_i wins
    always_comb begin
        idx_o = '0;
        j     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = IW'((int'(ptr_i) + i) % NUM_REQ);
            if (req_i[j]) idx_o = j;
        end
    end

    assign any_o = |req_i;
endmodule

// File: rtl/trng_arbiter.sv
// trng_arbiter: shares one TRNG sample source among requesters, packing samples into words
module trng_arbiter
    import trng_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TRNG_WIDTH     = 4,
    parameter int OUT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  resetn,
    trng_arbiter_if.slave         bus,
    output logic                  busy_o,
    output logic                  trng_req,
    input  logic [TRNG_WIDTH-1:0] trng_word,
    input  logic                  trng_valid
);
    localparam int SAMPLES = samples_of(OUT_WIDTH, TRNG_WIDTH);
    localparam int IW      = idx_w(NUM_REQ);
    localparam int CW      = ctr_w(SAMPLES);
    localparam int TW      = ctr_w(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d, ptr_q, ptr_d, pick;
    logic [OUT_WIDTH-1:0] acc_q, acc_d, data_q, data_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [NUM_REQ-1:0]   vld_q, vld_d;
    logic                 err_q, err_d, req_q, req_d, busy_q, busy_d, any;
    logic                 tmo_hit;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i (bus.req_i),
        .ptr_i (ptr_q),
        .idx_o (pick),
        .any_o (any)
    );

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

    // next-state logic: arbitration, sample packing, time-out and one-cycle response
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        req_d   = req_q;
        vld_d   = '0;
        err_d   = 1'b0;
        data_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (any) begin
                    grant_d = pick;
                    acc_d   = '0;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TW'(1);
                if (trng_valid) begin
                    acc_d = (acc_q << TRNG_WIDTH) | OUT_WIDTH'(trng_word);
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
                    req_d = 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DELIVER;
                        vld_d   = NUM_REQ'(1) << grant_q;
                        data_d  = acc_d;
                    end else begin
                        state_d = S_REARM;
                    end
                end else if (tmo_hit) begin
                    req_d   = 1'b0;
                    acc_d   = '0;
                    err_d   = 1'b1;
                    vld_d   = NUM_REQ'(1) << grant_q;
                    state_d = S_DELIVER;
                end
            end
            S_REARM: begin
                tmo_d   = '0;
                req_d   = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                ptr_d   = grant_q;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // state and registered outputs; reset drops trng_req without waiting for a clock
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            acc_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b0;
            vld_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.rsp_valid_o = vld_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.rsp_data_o  = data_q;
    assign busy_o          = busy_q;
    assign trng_req        = req_q;
endmodule

// File: tb/tb_trng_arbiter.sv
// tb_trng_arbiter: directed checks of the TRNG arbiter with a small programmable sample source
module tb_trng_arbiter;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       busy, trng_req, trng_valid;
    logic [3:0] trng_word;
    int         total = 0;
    int         bad = 0;
    int         n;

    logic       src_on = 1'b0;
    logic       src_rst = 1'b0;
    logic       man_v = 1'b0;
    logic [3:0] man_w = 4'h0;
    logic [3:0] smp [8];
    int         dly [8];
    int         sidx = 0;
    int         wcnt = 0;

    always #5 clk = ~clk;

    trng_arbiter_if #(.NUM_REQ(2), .OUT_WIDTH(32)) bus ();

    trng_arbiter #(
        .NUM_REQ(2), .TRNG_WIDTH(4), .OUT_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .busy_o     (busy),
        .trng_req   (trng_req),
        .trng_word  (trng_word),
        .trng_valid (trng_valid)
    );

    // source answers a request after dly[sidx] cycles of trng_req high; man_v forces a pulse
    assign trng_valid = man_v | (src_on & trng_req & (wcnt >= dly[sidx]));
    assign trng_word  = man_v ? man_w : smp[sidx];

    always @(posedge clk) begin
        if (src_rst) begin
            sidx <= 0;
            wcnt <= 0;
        end else begin
            if (trng_valid && trng_req && !man_v) sidx <= (sidx + 1) % 8;
            wcnt <= (trng_req && !trng_valid) ? wcnt + 1 : 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input logic [31:0] w, input int last_dly);
        for (int i = 0; i < 8; i++) begin
            smp[i] = w[31-4*i -: 4];
            dly[i] = (i == 7) ? last_dly : 0;
        end
        src_rst = 1'b1;
        tick();
        src_rst = 1'b0;
    endtask

    task automatic wait_rsp(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (bus.rsp_valid_o == 2'b00 && cnt < 200);
    endtask

    task automatic feed(input logic [3:0] w);
        int k;
        k = 0;
        while (!trng_req && k < 20) begin
            tick();
            k++;
        end
        chk("feed_req", 64'(trng_req), 64'(1));
        man_w = w;
        man_v = 1'b1;
        tick();
        man_v = 1'b0;
    endtask

    initial begin
        logic [31:0] w4;
        bus.req_i = 2'b00;
        for (int i = 0; i < 8; i++) begin
            smp[i] = 4'h0;
            dly[i] = 0;
        end
        repeat (3) tick();
        chk("rst_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("rst_err", 64'(bus.rsp_err_o), 64'(0));
        chk("rst_data", 64'(bus.rsp_data_o), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_trng_req", 64'(trng_req), 64'(0));
        resetn = 1'b1;
        tick();

        // single word, zero-wait source: response 16 cycles after the request is seen
        set_src(32'h12345678, 0);
        src_on = 1'b1;
        bus.req_i = 2'b01;
        wait_rsp(n);
        chk("t1_latency", 64'(n), 64'(16));
        chk("t1_valid", 64'(bus.rsp_valid_o), 64'(2'b01));
        chk("t1_data", 64'(bus.rsp_data_o), 64'(32'h12345678));
        chk("t1_err", 64'(bus.rsp_err_o), 64'(0));
        bus.req_i = 2'b00;
        tick();
        chk("t1_valid_drop", 64'(bus.rsp_valid_o), 64'(0));
        chk("t1_data_drop", 64'(bus.rsp_data_o), 64'(0));
        chk("t1_busy_drop", 64'(busy), 64'(0));

        // both requesting: pointer sits at 0 after the previous grant, so 1 goes first
        bus.req_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(n);
            chk("t2_latency", 64'(n), 64'((k == 0) ? 16 : 17));
            chk("t2_grant", 64'(bus.rsp_valid_o), 64'((k % 2 == 0) ? 2'b10 : 2'b01));
            chk("t2_data", 64'(bus.rsp_data_o), 64'(32'h12345678));
            if (k == 3) bus.req_i = 2'b00;
        end
        tick();
        chk("t2_busy_drop", 64'(busy), 64'(0));

        // silent source: time-out after 16 FETCH cycles, error response with zero data
        src_on = 1'b0;
        bus.req_i = 2'b10;
        tick();
        chk("t3_req_rise", 64'(trng_req), 64'(1));
        n = 0;
        do begin
            tick();
            n++;
        end while (trng_req && n < 100);
        chk("t3_req_len", 64'(n), 64'(16));
        chk("t3_valid", 64'(bus.rsp_valid_o), 64'(2'b10));
        chk("t3_err", 64'(bus.rsp_err_o), 64'(1));
        chk("t3_data", 64'(bus.rsp_data_o), 64'(0));
        bus.req_i = 2'b00;
        tick();
        chk("t3_valid_drop", 64'(bus.rsp_valid_o), 64'(0));
        chk("t3_err_drop", 64'(bus.rsp_err_o), 64'(0));
        chk("t3_busy_drop", 64'(busy), 64'(0));

        // stray pulses in IDLE and every REARM cycle must not reach the word
        man_w = 4'hF;
        man_v = 1'b1;
        tick();
        man_v = 1'b0;
        bus.req_i = 2'b01;
        tick();
        w4 = 32'hABCDE987;
        for (int i = 0; i < 8; i++) begin
            feed(w4[31-4*i -: 4]);
            if (i < 7) begin
                chk("t4_rearm_req", 64'(trng_req), 64'(0));
                man_w = 4'hF;
                man_v = 1'b1;
                tick();
                man_v = 1'b0;
            end
        end
        chk("t4_valid", 64'(bus.rsp_valid_o), 64'(2'b01));
        chk("t4_data", 64'(bus.rsp_data_o), 64'(32'hABCDE987));
        chk("t4_err", 64'(bus.rsp_err_o), 64'(0));
        bus.req_i = 2'b00;
        tick();

        // reset in the FETCH after the third sample, then a fresh word
        set_src(32'h12345678, 0);
        src_on = 1'b1;
        bus.req_i = 2'b01;
        repeat (7) tick();
        chk("t5_pre_req", 64'(trng_req), 64'(1));
        resetn = 1'b0;
        #1;
        chk("t5_async_req", 64'(trng_req), 64'(0));
        chk("t5_async_busy", 64'(busy), 64'(0));
        chk("t5_async_valid", 64'(bus.rsp_valid_o), 64'(0));
        set_src(32'h9ABCDEF0, 0);
        resetn = 1'b1;
        wait_rsp(n);
        chk("t5_latency", 64'(n), 64'(16));
        chk("t5_valid", 64'(bus.rsp_valid_o), 64'(2'b01));
        chk("t5_data", 64'(bus.rsp_data_o), 64'(32'h9ABCDEF0));
        chk("t5_err", 64'(bus.rsp_err_o), 64'(0));
        bus.req_i = 2'b00;
        tick();

        // final sample lands on the 16th FETCH cycle: valid beats the time-out
        set_src(32'h12345678, 15);
        bus.req_i = 2'b01;
        wait_rsp(n);
        chk("t6_latency", 64'(n), 64'(31));
        chk("t6_valid", 64'(bus.rsp_valid_o), 64'(2'b01));
        chk("t6_data", 64'(bus.rsp_data_o), 64'(32'h12345678));
        chk("t6_err", 64'(bus.rsp_err_o), 64'(0));
        bus.req_i = 2'b00;
        tick();

        // one cycle later than that: the time-out wins and the partial word is discarded
        set_src(32'h12345678, 16);
        bus.req_i = 2'b01;
        wait_rsp(n);
        chk("t7_latency", 64'(n), 64'(31));
        chk("t7_valid", 64'(bus.rsp_valid_o), 64'(2'b01));
        chk("t7_data", 64'(bus.rsp_data_o), 64'(0));
        chk("t7_err", 64'(bus.rsp_err_o), 64'(1));
        bus.req_i = 2'b00;
        tick();
        chk("t7_busy_drop", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
